// File: rtl/uart_xmit_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: data width and the
// arbiter state encoding.
package uart_xmit_arb_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    ACK        = 3'd4
  } arbState_t;

endpackage

// File: rtl/uart_xmit_arb_rr_pick.sv
// Round-robin selector: finds the first active request after lastOwner,
// wrapping from NUM_REQ-1 back to 0. Purely combinational.
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         lastOwner,
  output logic               valid,
  output logic [2:0]         index
);

  int dist_s;
  int bestDist_s;

  // Pick the requester with the smallest rotational distance from lastOwner+1.
  always_comb begin
    valid      = 1'b0;
    index      = 3'd0;
    dist_s     = 0;
    bestDist_s = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s = (i + 2 * NUM_REQ - int'(lastOwner) - 1) % NUM_REQ;
      if (req[i] && (dist_s < bestDist_s)) begin
        valid      = 1'b1;
        index      = 3'(i);
        bestDist_s = dist_s;
      end else begin
        bestDist_s = bestDist_s;
      end
    end
  end

endmodule

// File: rtl/uart_xmit_arb.sv
// Arbiter sharing one UART transmitter among NUM_REQ requesters. Grants
// round-robin, launches the transmitter, waits for it to start and finish
// (with a start timeout), then acknowledges the owner.
module uart_xmit_arb
  import uart_xmit_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int START_TMO = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_l,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      ack_err,
  output logic                      xmitH,
  output logic [DATA_W-1:0]         xmit_dataH,
  input  logic                      xmit_doneH,
  output logic                      busy,
  output logic [2:0]                owner
);

  localparam int              TMO_W     = $clog2(START_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(START_TMO - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(START_TMO);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [2:0]       LAST_INIT = 3'(NUM_REQ - 1);

  arbState_t          state_r;
  arbState_t          nextState_s;
  logic [TMO_W-1:0]   tmoCnt_r;
  logic [TMO_W-1:0]   nextCnt_s;
  logic [2:0]         lastOwner_r;
  logic [2:0]         nextOwner_s;
  logic [DATA_W-1:0]  nextData_s;
  logic [DATA_W-1:0]  pickData_s;
  logic               nextErr_s;
  logic [NUM_REQ-1:0] ackNext_s;
  logic               pickValid_s;
  logic [2:0]         pickIdx_s;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) uRrPick (
    .req       (req),
    .lastOwner (lastOwner_r),
    .valid     (pickValid_s),
    .index     (pickIdx_s)
  );

  // Select the byte belonging to the requester the picker chose.
  always_comb begin
    pickData_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickIdx_s == 3'(i)) begin
        pickData_s = req_data[i*DATA_W +: DATA_W];
      end else begin
        pickData_s = pickData_s;
      end
    end
  end

  // Next-state, timeout counter and next-output computation.
  always_comb begin
    nextState_s = state_r;
    nextCnt_s   = tmoCnt_r;
    nextOwner_s = owner;
    nextData_s  = xmit_dataH;
    nextErr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pickValid_s && xmit_doneH) begin
          nextState_s = LAUNCH;
          nextOwner_s = pickIdx_s;
          nextData_s  = pickData_s;
        end else begin
          nextState_s = IDLE;
        end
      end
      LAUNCH: begin
        nextState_s = WAIT_START;
        nextCnt_s   = {TMO_W{1'b0}};
      end
      WAIT_START: begin
        if (!xmit_doneH) begin
          nextState_s = WAIT_DONE;
        end else if (tmoCnt_r >= TMO_LAST) begin
          nextState_s = ACK;
          nextErr_s   = 1'b1;
        end else if (tmoCnt_r == TMO_MAX) begin
          nextCnt_s = TMO_MAX;
        end else begin
          nextCnt_s = tmoCnt_r + TMO_ONE;
        end
      end
      WAIT_DONE: begin
        if (xmit_doneH) begin
          nextState_s = ACK;
        end else begin
          nextState_s = WAIT_DONE;
        end
      end
      ACK: begin
        nextState_s = IDLE;
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
    if (nextState_s == ACK) begin
      ackNext_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << nextOwner_s;
    end else begin
      ackNext_s = {NUM_REQ{1'b0}};
    end
  end

  // State and registered outputs; async reset aborts any frame silently.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_r     <= IDLE;
      tmoCnt_r    <= {TMO_W{1'b0}};
      lastOwner_r <= LAST_INIT;
      owner       <= 3'd0;
      xmit_dataH  <= {DATA_W{1'b0}};
      xmitH       <= 1'b0;
      busy        <= 1'b0;
      ack         <= {NUM_REQ{1'b0}};
      ack_err     <= 1'b0;
    end else begin
      state_r     <= nextState_s;
      tmoCnt_r    <= nextCnt_s;
      lastOwner_r <= (state_r == ACK) ? owner : lastOwner_r;
      owner       <= nextOwner_s;
      xmit_dataH  <= nextData_s;
      xmitH       <= (nextState_s == LAUNCH);
      busy        <= (nextState_s != IDLE);
      ack         <= ackNext_s;
      ack_err     <= nextErr_s;
    end
  end

endmodule

// File: tb/tb_uart_xmit_arb.sv
// Self-checking bench for uart_xmit_arb: directed scenarios plus a random
// phase, checked against a round-robin reference model.
module tb_uart_xmit_arb;

  localparam int NR  = 4;
  localparam int TMO = 16;

  logic            sys_clk    = 1'b0;
  logic            sys_rst_l  = 1'b1;
  logic [NR-1:0]   req        = '0;
  logic [NR*8-1:0] req_data   = '0;
  logic [NR-1:0]   ack;
  logic            ack_err;
  logic            xmitH;
  logic [7:0]      xmit_dataH;
  logic            xmit_doneH = 1'b1;
  logic            busy;
  logic [2:0]      owner;

  int checks    = 0;
  int failures  = 0;
  int fallDly   = 2;
  int riseDly   = 20;
  bit stuckMode = 1'b0;
  int mLast     = NR - 1;

  always #5 sys_clk = ~sys_clk;

  uart_xmit_arb #(.NUM_REQ(NR), .START_TMO(TMO)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .ack_err    (ack_err),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .xmit_doneH (xmit_doneH),
    .busy       (busy),
    .owner      (owner)
  );

  // Transmitter model: doneH falls fallDly cycles after a launch, rises riseDly later.
  initial begin
    forever begin
      @(posedge sys_clk);
      if (xmitH === 1'b1 && !stuckMode) begin
        repeat (fallDly) @(posedge sys_clk);
        #1 xmit_doneH = 1'b0;
        repeat (riseDly) @(posedge sys_clk);
        #1 xmit_doneH = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first requesting index after the last owner, wrapping.
  function automatic int predict(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [7:0] byteOf(input int i);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < NR; k++) begin
      if (k == i) b = req_data[8*k +: 8];
    end
    return b;
  endfunction

  task automatic setByte(input int i, input logic [7:0] v);
    for (int k = 0; k < NR; k++) begin
      if (k == i) req_data[8*k +: 8] = v;
    end
  endtask

  task automatic waitLaunch(input int expIdx, input logic [7:0] expData);
    int n;
    logic prevBusy;
    n = 0;
    prevBusy = busy;
    @(negedge sys_clk);
    while (xmitH !== 1'b1 && n < 300) begin
      prevBusy = busy;
      @(negedge sys_clk);
      n++;
    end
    check("launch_seen", 32'(n < 300), 32'd1);
    check("launch_owner", 32'(owner), 32'(expIdx));
    check("launch_data", 32'(xmit_dataH), 32'(expData));
    check("launch_busy", 32'(busy), 32'd1);
    check("busy_before_grant", 32'(prevBusy), 32'd0);
  endtask

  task automatic waitAck(input int expIdx, input logic [7:0] expData, input bit expErr,
                         input logic [NR-1:0] dropMask, output int cycles);
    int n;
    int extra;
    n = 0;
    extra = 0;
    do begin
      @(negedge sys_clk);
      n++;
      if (xmitH === 1'b1) extra++;
    end while (ack === '0 && n < 400);
    req = req & ~dropMask;
    check("ack_seen", 32'(n < 400), 32'd1);
    check("ack_vector", 32'(ack), 32'(1 << expIdx));
    check("ack_err", 32'(ack_err), 32'(expErr));
    check("data_hold", 32'(xmit_dataH), 32'(expData));
    check("single_launch", 32'(extra), 32'd0);
    mLast = expIdx;
    cycles = n;
    @(negedge sys_clk);
    check("ack_one_cycle", 32'(ack), 32'd0);
    check("idle_after_ack", 32'(busy), 32'd0);
  endtask

  task automatic frame(input bit expErr, input logic [NR-1:0] dropMask, output int cycles);
    int e;
    logic [7:0] d;
    e = predict(req, mLast);
    d = byteOf(e);
    waitLaunch(e, d);
    waitAck(e, d, expErr, dropMask, cycles);
  endtask

  initial begin
    int cyc;
    int e;
    int n;
    bit sawAck;
    logic [7:0] d;

    // Reset values
    #2 sys_rst_l = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("rst_xmitH", 32'(xmitH), 32'd0);
    check("rst_data", 32'(xmit_dataH), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    sys_rst_l = 1'b1;
    @(negedge sys_clk);

    // Fairness: all four requesting, expect 0,1,2,3,0
    for (int i = 0; i < NR; i++) setByte(i, 8'(8'h10 + i));
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      frame(1'b0, (f == 4) ? 4'b1111 : 4'b0000, cyc);
    end

    // Single requester with a nominal transmitter
    setByte(0, 8'hA5);
    fallDly = 2;
    riseDly = 20;
    req = 4'b0001;
    frame(1'b0, 4'b0001, cyc);

    // Wrap: make 3 the last owner, then 0 then 3
    setByte(3, 8'($urandom));
    req = 4'b1000;
    frame(1'b0, 4'b1000, cyc);
    setByte(0, 8'($urandom));
    req = 4'b1001;
    frame(1'b0, 4'b0001, cyc);
    frame(1'b0, 4'b1000, cyc);

    // Start timeout: transmitter never drops doneH
    stuckMode = 1'b1;
    setByte(1, 8'($urandom));
    req = 4'b0010;
    frame(1'b1, 4'b0010, cyc);
    check("tmo_latency", 32'(cyc), 32'(TMO + 1));
    stuckMode = 1'b0;

    // Busy hold: owner changes data and drops req mid-frame, req1 waits
    setByte(0, 8'hA5);
    req = 4'b0001;
    e = predict(req, mLast);
    waitLaunch(e, 8'hA5);
    @(negedge sys_clk);
    setByte(0, 8'hFF);
    setByte(1, 8'h3C);
    req = 4'b0010;
    check("hold_owner", 32'(owner), 32'd0);
    waitAck(e, 8'hA5, 1'b0, 4'b0000, cyc);
    frame(1'b0, 4'b0010, cyc);

    // Reset during WAIT_DONE
    setByte(0, 8'($urandom));
    setByte(2, 8'($urandom));
    req = 4'b0101;
    e = predict(req, mLast);
    d = byteOf(e);
    waitLaunch(e, d);
    n = 0;
    while (xmit_doneH !== 1'b0 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    check("tx_started", 32'(n < 50), 32'd1);
    repeat (2) @(negedge sys_clk);
    sys_rst_l = 1'b0;
    #1;
    check("mid_rst_xmitH", 32'(xmitH), 32'd0);
    check("mid_rst_data", 32'(xmit_dataH), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_ack_err", 32'(ack_err), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_owner", 32'(owner), 32'd0);
    sawAck = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      if (ack !== '0) sawAck = 1'b1;
    end
    check("no_ack_on_reset", 32'(sawAck), 32'd0);
    sys_rst_l = 1'b1;
    mLast = NR - 1;
    frame(1'b0, 4'b0001, cyc);
    frame(1'b0, 4'b0100, cyc);

    // Random traffic
    for (int f = 0; f < 12; f++) begin
      if (req == '0) begin
        req = 4'($urandom_range(1, 15));
        for (int i = 0; i < NR; i++) setByte(i, 8'($urandom));
      end
      fallDly = int'($urandom_range(1, 4));
      riseDly = int'($urandom_range(3, 25));
      e = predict(req, mLast);
      frame(1'b0, 4'(1 << e), cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_xmit_arb.md
UART_XMIT_ARB -- requirements
Module: uart_xmit_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the transmitter (2..8).
REQ-002 SHALL have parameter START_TMO, default 16, max cycles to wait for the transmitter to drop xmit_doneH after launch.
REQ-003 SHALL have port sys_clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port sys_rst_l  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester send request; level, held until ack.
REQ-006 SHALL have port req_data  input  NUM_REQ*8  byte per requester; requester i uses bits [8i+7:8i], stable while req[i]=1.
REQ-007 SHALL have port ack  output  NUM_REQ  one-cycle completion pulse to requester.
REQ-008 SHALL have port ack_err  output  1  qualifies ack: 1 = frame aborted by start timeout.
REQ-009 SHALL have port xmitH  output  1  launch pulse to the shared transmitter.
REQ-010 SHALL have port xmit_dataH  output  8  byte to the transmitter.
REQ-011 SHALL have port xmit_doneH  input  1  transmitter idle/done level: 1 idle, 0 shifting.
REQ-012 SHALL have port busy  output  1  arbiter not in IDLE.
REQ-013 SHALL have port owner  output  3  index of granted requester, valid while busy.

Function
REQ-014 SHALL implement states IDLE, LAUNCH, WAIT_START, WAIT_DONE, ACK.
REQ-015 IDLE: when any req bit = 1 and xmit_doneH = 1, SHALL grant round-robin starting at (last_owner+1) mod NUM_REQ, latch req_data byte into xmit_dataH, set owner, go to LAUNCH.
REQ-016 IDLE with xmit_doneH = 0 SHALL not grant.
REQ-017 LAUNCH SHALL drive xmitH = 1 for exactly one cycle, then go to WAIT_START.
REQ-018 WAIT_START SHALL go to WAIT_DONE on xmit_doneH = 0; after START_TMO cycles without it, SHALL go to ACK with ack_err = 1.
REQ-019 WAIT_DONE SHALL go to ACK when xmit_doneH returns to 1; no timeout.
REQ-020 ACK SHALL pulse ack[owner] for one cycle (ack_err valid same cycle), update last_owner = owner, return to IDLE.
REQ-021 Grant-to-xmitH latency SHALL be 1 cycle; at most one ack bit SHALL ever be high.
REQ-022 xmit_dataH SHALL hold the latched byte from grant until next grant; later changes to req/req_data of the owner SHALL be ignored.
REQ-023 Requests arriving while busy SHALL wait; the owner's own req deasserting mid-frame SHALL still receive ack.
REQ-024 Round-robin pointer SHALL wrap from NUM_REQ-1 to 0; after reset last_owner = NUM_REQ-1 so requester 0 has first priority.
REQ-025 Timeout counter SHALL be ceil(log2(START_TMO+1)) bits, cleared on entry to WAIT_START, saturating.

Reset
REQ-026 On sys_rst_l = 0 SHALL asynchronously enter IDLE; xmitH=0, xmit_dataH=0, ack=0, ack_err=0, busy=0, owner=0, last_owner=NUM_REQ-1, counter=0.
REQ-027 Reset mid-frame SHALL abort without ack; transmitter state is not touched.

Structure
REQ-028 State encoding and the 8-bit data width constant SHALL live in the shared UART package/include.
REQ-029 Round-robin selection SHALL be one combinational sub-module uart_rr_pick (inputs req, last_owner; outputs valid, index).

Verification
REQ-030 Single: req=4'b0001, data0=8'hA5, model doneH falls 2 cycles after xmitH, rises 20 later -> one xmitH with xmit_dataH=A5, ack=4'b0001, ack_err=0.
REQ-031 Fairness: req=4'b1111 held, data i=8'h10+i -> transmit order 0,1,2,3,0; each ack once per round.
REQ-032 Wrap: last owner 3, req=4'b1001 -> requester 0 granted next, then 3.
REQ-033 Timeout: doneH stuck at 1 after launch -> ack pulse after START_TMO=16 cycles with ack_err=1, back to IDLE.
REQ-034 Busy hold: owner changes data0 to 8'hFF mid-frame -> xmit_dataH stays A5; req1 raised mid-frame granted only after ack.
REQ-035 Reset: assert sys_rst_l=0 in WAIT_DONE -> all outputs zero next edge-free instant, no ack; after release requester 0 wins.
